// File: rtl/spi_deserializer.sv
// spi_deserializer: receive side of the SPI link. Samples mosi on rising sclk
// (MSB first), assembles DATA_WIDTH-bit words, pushes each into the receive
// FIFO with a one-cycle write strobe and reports overflow / malformed frames
// through sticky flags.
// Optional feature: define SPI_RX_TIMEOUT_EN to add an idle watchdog that
// aborts a partial word after TIMEOUT_CYCLES clk cycles without an sclk rise.
module spi_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  done_in,
  input  logic                  full,
  input  logic                  clear_err,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  sclk_q;
  logic                  rise;
  logic [CW-1:0]         bit_cnt, cnt_next, cnt_inc;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] last_word;
  logic                  capture;
  logic                  ovf_set, ferr_set;
  logic                  timeout;

  assign rise    = sclk & ~sclk_q;
  assign cnt_inc = bit_cnt + CW'(1);

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] idle_cnt;

  // Idle watchdog: counts clk cycles without a rise while a word is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (state != RECV || rise) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TW'(TIMEOUT_CYCLES - 1)) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // The TIMEOUT_CYCLES-th consecutive idle cycle aborts; a rise always wins.
  assign timeout = (state == RECV) && !rise && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state, capture and flag-set decisions.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    capture    = 1'b0;
    ovf_set    = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          capture    = 1'b1;
          cnt_next   = cnt_inc;
          state_next = (cnt_inc == CW'(DATA_WIDTH)) ? WRITE : RECV;
        end
      end
      RECV: begin
        if (done_in) begin
          // Serializer ended the word early: discard it, and any rise with it.
          ferr_set   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (rise) begin
          capture  = 1'b1;
          cnt_next = cnt_inc;
          if (cnt_inc == CW'(DATA_WIDTH)) state_next = WRITE;
        end else if (timeout) begin
          ferr_set   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      WRITE: begin
        ovf_set = full;
        if (rise) begin
          // Start of the next word arrives while this one is being written.
          capture    = 1'b1;
          cnt_next   = CW'(1);
          state_next = RECV;
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign shift_next = capture ? {shift_reg[DATA_WIDTH-2:0], mosi} : shift_reg;

  // FSM, bit counter, shift register and edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      sclk_q    <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= cnt_next;
      shift_reg <= shift_next;
      sclk_q    <= sclk;
    end
  end

  // Last word handed to the FIFO, so write_data holds outside WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_word <= '0;
    end else if (state == WRITE && !full) begin
      last_word <= shift_reg;
    end
  end

  // Sticky flags; a set in the same cycle as clear_err takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_set  | (overflow  & ~clear_err);
      frame_err <= ferr_set | (frame_err & ~clear_err);
    end
  end

  assign write_en   = (state == WRITE) && !full;
  assign write_data = (state == WRITE) ? shift_reg : last_word;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_spi_deserializer.sv
// Directed self-checking bench for spi_deserializer (DATA_WIDTH=8).
module tb_spi_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       done_in;
  logic       full;
  logic       clear_err;
  logic       write_en;
  logic [7:0] write_data;
  logic       busy;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int passed = 0;
  int wr_count = 0;

  spi_deserializer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .mosi       (mosi),
    .done_in    (done_in),
    .full       (full),
    .clear_err  (clear_err),
    .write_en   (write_en),
    .write_data (write_data),
    .busy       (busy),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Count every FIFO write strobe seen.
  always @(negedge clk) if (write_en === 1'b1) wr_count++;

  // One serializer bit period: 2 cycles high, 2 cycles low. If sample is set,
  // write_en/write_data are captured in the cycle after the rise is taken.
  task automatic send_bit(input logic b, input logic sample,
                          output logic we, output logic [7:0] wd);
    @(negedge clk); mosi = b; sclk = 1'b1;
    @(negedge clk);
    we = write_en; wd = write_data;
    if (!sample) begin we = 1'bx; wd = 'x; end
    sclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, output logic we, output logic [7:0] wd);
    logic       t_we;
    logic [7:0] t_wd;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], (i == 0), t_we, t_wd);
    end
    we = t_we; wd = t_wd;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    logic       t_we;
    logic [7:0] t_wd;
    for (int i = 0; i < n; i++) send_bit(w[7-i], 1'b0, t_we, t_wd);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b0; sclk = 1'b0; mosi = 1'b0; done_in = 1'b0; full = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_write_en", {31'd0, write_en}, 32'd0);
    chk("reset_write_data", {24'd0, write_data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word;
    logic we; logic [7:0] wd; int c0;
    c0 = wr_count;
    send_word(8'hA5, we, wd);
    chk("word_write_en", {31'd0, we}, 32'd1);
    chk("word_write_data", {24'd0, wd}, 32'hA5);
    chk("word_pulse_count", wr_count - c0, 32'd1);
    chk("word_busy_after", {31'd0, busy}, 32'd0);
    chk("word_data_held", {24'd0, write_data}, 32'hA5);
  endtask

  task automatic test_overflow;
    logic we; logic [7:0] wd; int c0;
    c0 = wr_count;
    full = 1'b1;
    send_word(8'h3C, we, wd);
    full = 1'b0;
    chk("ovf_no_write_en", {31'd0, we}, 32'd0);
    chk("ovf_no_pulse", wr_count - c0, 32'd0);
    chk("ovf_flag_set", {31'd0, overflow}, 32'd1);
    repeat (5) @(negedge clk);
    chk("ovf_flag_held", {31'd0, overflow}, 32'd1);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("ovf_flag_cleared", {31'd0, overflow}, 32'd0);
  endtask

  task automatic test_early_done;
    logic we; logic [7:0] wd; int c0;
    c0 = wr_count;
    send_bits(8'hF0, 5);
    chk("early_busy_mid", {31'd0, busy}, 32'd1);
    done_in = 1'b1; @(negedge clk); done_in = 1'b0;
    chk("early_frame_err", {31'd0, frame_err}, 32'd1);
    chk("early_busy_idle", {31'd0, busy}, 32'd0);
    chk("early_no_write", wr_count - c0, 32'd0);
    send_word(8'h81, we, wd);
    chk("early_next_we", {31'd0, we}, 32'd1);
    chk("early_next_data", {24'd0, wd}, 32'h81);
    chk("early_ferr_sticky", {31'd0, frame_err}, 32'd1);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("early_ferr_cleared", {31'd0, frame_err}, 32'd0);
  endtask

  task automatic test_back_to_back;
    logic we; logic [7:0] wd; int c0;
    c0 = wr_count;
    send_word(8'hFF, we, wd);
    chk("b2b_first_we", {31'd0, we}, 32'd1);
    chk("b2b_first_data", {24'd0, wd}, 32'hFF);
    send_word(8'h00, we, wd);
    chk("b2b_second_we", {31'd0, we}, 32'd1);
    chk("b2b_second_data", {24'd0, wd}, 32'h00);
    chk("b2b_pulse_count", wr_count - c0, 32'd2);
  endtask

  task automatic test_reset_midframe;
    int c0;
    // Leave write_data at a non-zero value so the async reset is visible.
    begin
      logic we; logic [7:0] wd;
      send_word(8'h5A, we, wd);
    end
    c0 = wr_count;
    send_bits(8'hFF, 4);
    chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_write_en", {31'd0, write_en}, 32'd0);
    chk("rstmid_write_data", {24'd0, write_data}, 32'd0);
    chk("rstmid_overflow", {31'd0, overflow}, 32'd0);
    chk("rstmid_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rstmid_no_write", wr_count - c0, 32'd0);
  endtask

  task automatic test_timeout;
    send_bits(8'hE0, 3);
    // send_bits already left sclk low for 2 cycles; hold well past 64 more.
    repeat (80) @(negedge clk);
`ifdef SPI_RX_TIMEOUT_EN
    chk("timeout_frame_err", {31'd0, frame_err}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
`else
    chk("timeout_frame_err", {31'd0, frame_err}, 32'd0);
    chk("timeout_busy", {31'd0, busy}, 32'd1);
`endif
  endtask

  initial begin
    test_reset;
    test_word;
    test_overflow;
    test_early_done;
    test_back_to_back;
    test_reset_midframe;
    test_timeout;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
